// File: rtl/decode_check_sequencer_if.sv
// Bus bundle for decode_check_sequencer: vector-table load port, run control, decode loop and results.
// The loop_mode/stop/pass_count signals exist only when DECODE_SEQ_LOOP_EN is defined.
interface decode_check_sequencer_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int CTRL_WIDTH  = 29,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                   load_valid;
    logic [AW-1:0]          load_addr;
    logic [INSTR_WIDTH-1:0] load_instr;
    logic [CTRL_WIDTH-1:0]  load_expect;
    logic [CTRL_WIDTH-1:0]  load_mask;
    logic [AW:0]            num_vectors;
    logic                   start;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [CTRL_WIDTH-1:0]  ctrl_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [CNT_WIDTH-1:0]   mismatch_count;
    logic [AW-1:0]          first_fail;
    logic                   fail_seen;
`ifdef DECODE_SEQ_LOOP_EN
    logic                   loop_mode;
    logic                   stop;
    logic [CNT_WIDTH-1:0]   pass_count;
`endif

    modport master (
        output load_valid, load_addr, load_instr, load_expect, load_mask,
        output num_vectors, start, ctrl_in,
`ifdef DECODE_SEQ_LOOP_EN
        output loop_mode, stop,
        input  pass_count,
`endif
        input  instr_out, busy, done, pass, mismatch_count, first_fail, fail_seen
    );

    modport slave (
        input  load_valid, load_addr, load_instr, load_expect, load_mask,
        input  num_vectors, start, ctrl_in,
`ifdef DECODE_SEQ_LOOP_EN
        input  loop_mode, stop,
        output pass_count,
`endif
        output instr_out, busy, done, pass, mismatch_count, first_fail, fail_seen
    );
endinterface

// File: rtl/decode_check_sequencer.sv
// Plays a loadable table of instructions onto the decode path and checks the returned control bundle under a mask.
// Optional looping mode (loop_mode/stop/pass_count) is enabled by defining DECODE_SEQ_LOOP_EN.
module decode_check_sequencer #(
    parameter int INSTR_WIDTH = 32,
    parameter int CTRL_WIDTH  = 29,
    parameter int DEPTH       = 16,
    parameter int STEP_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input logic clk,
    input logic reset,
    decode_check_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

    logic [INSTR_WIDTH-1:0] instrMem  [DEPTH];
    logic [CTRL_WIDTH-1:0]  expectMem [DEPTH];
    logic [CTRL_WIDTH-1:0]  maskMem   [DEPTH];

    stateType               state;
    logic [AW-1:0]          idx;
    logic [SW-1:0]          step;
    logic [NW-1:0]          numLatched;
    logic                   issuing;
    logic                   checkPending;
    logic [CTRL_WIDTH-1:0]  sampleCtrl;
    logic [AW-1:0]          sampleIdx;
    logic [INSTR_WIDTH-1:0] instrOut;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [CNT_WIDTH-1:0]   mismatchCount;
    logic [AW-1:0]          firstFail;
    logic                   failSeen;
`ifdef DECODE_SEQ_LOOP_EN
    logic                   loopLatched;
    logic                   stopReq;
    logic [CNT_WIDTH-1:0]   passCount;
`endif

    logic [NW-1:0]          numClamped;
    logic [INSTR_WIDTH-1:0] firstInstr;
    logic [AW-1:0]          nextIdx;
    logic                   checkFail;
    logic                   anyFail;
    logic                   windowEnd;
    logic                   lastVec;
    logic                   finishNow;

    // The table is frozen while a run is in progress so every vector sees a stable entry.
    always_ff @(posedge clk) begin
        if (bus.load_valid && state != RUN) begin
            instrMem[bus.load_addr]  <= bus.load_instr;
            expectMem[bus.load_addr] <= bus.load_expect;
            maskMem[bus.load_addr]   <= bus.load_mask;
        end
    end

    // Entry 0 is bypassed from the load port so a same-cycle load+start drives the new instruction.
    always_comb begin
        numClamped = (bus.num_vectors > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_vectors;
        firstInstr = (bus.load_valid && bus.load_addr == '0) ? bus.load_instr : instrMem[0];
        nextIdx    = idx + 1'b1;
        checkFail  = checkPending &&
                     (((sampleCtrl ^ expectMem[sampleIdx]) & maskMem[sampleIdx]) != '0);
        anyFail    = failSeen || checkFail;
        windowEnd  = issuing && (step == SW'(STEP_CYCLES - 1));
        lastVec    = ({1'b0, idx} == (numLatched - NW'(1)));
`ifdef DECODE_SEQ_LOOP_EN
        finishNow  = stopReq || bus.stop || (lastVec && !loopLatched);
`else
        finishNow  = lastVec;
`endif
    end

    // Samples are compared one cycle after capture, so the drain cycle after the last window closes the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            step          <= '0;
            numLatched    <= '0;
            issuing       <= 1'b0;
            checkPending  <= 1'b0;
            sampleCtrl    <= '0;
            sampleIdx     <= '0;
            instrOut      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            mismatchCount <= '0;
            firstFail     <= '0;
            failSeen      <= 1'b0;
`ifdef DECODE_SEQ_LOOP_EN
            loopLatched   <= 1'b0;
            stopReq       <= 1'b0;
            passCount     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        numLatched    <= numClamped;
                        issuing       <= (numClamped != '0);
                        checkPending  <= 1'b0;
                        idx           <= '0;
                        step          <= '0;
                        mismatchCount <= '0;
                        firstFail     <= '0;
                        failSeen      <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        if (numClamped != '0) instrOut <= firstInstr;
`ifdef DECODE_SEQ_LOOP_EN
                        loopLatched   <= bus.loop_mode;
                        stopReq       <= 1'b0;
                        passCount     <= '0;
`endif
                    end
                end
                RUN: begin
                    checkPending <= 1'b0;
                    if (checkFail) begin
                        if (mismatchCount != '1) mismatchCount <= mismatchCount + 1'b1;
                        if (!failSeen) begin
                            firstFail <= sampleIdx;
                            failSeen  <= 1'b1;
                        end
                    end
`ifdef DECODE_SEQ_LOOP_EN
                    if (bus.stop) stopReq <= 1'b1;
`endif
                    if (windowEnd) begin
                        sampleCtrl   <= bus.ctrl_in;
                        sampleIdx    <= idx;
                        checkPending <= 1'b1;
                        step         <= '0;
                        if (finishNow) begin
                            issuing <= 1'b0;
`ifdef DECODE_SEQ_LOOP_EN
                        end else if (lastVec) begin
                            idx      <= '0;
                            instrOut <= instrMem[0];
                            if (passCount != '1) passCount <= passCount + 1'b1;
`endif
                        end else begin
                            idx      <= nextIdx;
                            instrOut <= instrMem[nextIdx];
                        end
                    end else if (issuing) begin
                        step <= step + 1'b1;
                    end
                    if (!issuing) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !anyFail;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_out      = instrOut;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.mismatch_count = mismatchCount;
    assign bus.first_fail     = firstFail;
    assign bus.fail_seen      = failSeen;
`ifdef DECODE_SEQ_LOOP_EN
    assign bus.pass_count     = passCount;
`endif
endmodule

// File: doc/decode_check_sequencer.md
Name: decode_check_sequencer

Overview:
- Synthesizable, parametrised successor to the hand-written decode stimulus bench.
- Holds a loadable table of instructions, each with its expected control bundle and a care mask.
- Plays the instructions one at a time onto the Processor decode path, holding each for STEP_CYCLES clocks, and samples the returned control bundle.
- Compares the sample under the mask, then reports pass/fail, a mismatch count and the first failing index.

Parameters:
- INSTR_WIDTH, 32: instruction width.
- CTRL_WIDTH, 29: packed control bundle width. Packing, MSB to LSB: regWriteFlag, opType[2:0], memWriteFlag, memReadFlag, aluControlCode[3:0], branchFlag, unconditionalBranchFlag, aluSRC, readRegister1[4:0], readRegister2[4:0], writeRegister[4:0], memToReg.
- DEPTH, 16: vector table entries (power of two, >=2).
- STEP_CYCLES, 2: cycles each instruction is held (>=1).
- CNT_WIDTH, 8: mismatch counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  write one table entry this cycle.
- load_addr  in  $clog2(DEPTH)  table entry index.
- load_instr  in  INSTR_WIDTH  instruction to store.
- load_expect  in  CTRL_WIDTH  expected control bundle.
- load_mask  in  CTRL_WIDTH  1 = compare this bit.
- num_vectors  in  $clog2(DEPTH)+1  vectors to run; latched at start.
- start  in  1  begin a run.
- instr_out  out  INSTR_WIDTH  instruction driven to decode.
- ctrl_in  in  CTRL_WIDTH  control bundle returned by decode.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid while done; 1 = zero mismatches.
- mismatch_count  out  CNT_WIDTH  failing vectors, saturating.
- first_fail  out  $clog2(DEPTH)  index of the first failing vector.
- fail_seen  out  1  first_fail is valid.

Behaviour:
- Reset: state IDLE. instr_out=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail=0, fail_seen=0. Table contents are not reset.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - Latch N=min(num_vectors,DEPTH).
  - Clear mismatch_count, fail_seen, first_fail, done, pass.
  - If N=0: go to DONE next cycle with pass=1.
  - Else: go to RUN with idx=0, step=0; instr_out=table[0].instr from the next cycle.
- RUN:
  - instr_out=table[idx].instr for exactly STEP_CYCLES cycles; step counts 0..STEP_CYCLES-1.
  - On the clock edge ending step=STEP_CYCLES-1, sample ctrl_in.
  - Vector fails if ((ctrl_in ^ expect) & mask) != 0.
  - On failure: mismatch_count increments, saturating at all-ones. If fail_seen=0, set first_fail=idx and fail_seen=1.
  - If idx=N-1: go to DONE, with done=1 and pass=(no failures including this one). Otherwise idx+1, step=0.
  - instr_out holds its last value in DONE.
- busy=1 exactly while in RUN.
- Latency: start accepted at edge t gives done=1 after edge t+N*STEP_CYCLES+1.
- start while busy: ignored.
- load_valid while busy: ignored; the table must not change mid-run.
- load_valid and start in the same cycle (not busy): the write lands first, so the run sees the new entry.
- load_valid in IDLE/DONE: written; does not affect done/pass.
- num_vectors>DEPTH: clamped to DEPTH.
- reset mid-run: returns to IDLE with all outputs at reset values the next cycle.
- Mask bits 0: never cause a failure.

Optional Feature:
- Macro DECODE_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_mode (1 bit), latched at start.
  - With loop_mode=1, after vector N-1 the sequencer wraps to idx=0 instead of entering DONE.
  - mismatch_count and first_fail keep accumulating across passes.
  - Adds input stop. stop=1 in RUN finishes the current vector's window, then enters DONE with pass reflecting all passes.
  - Adds output pass_count (CNT_WIDTH, saturating), which increments at each completed wrap.
- Undefined:
  - Ports loop_mode, stop and pass_count are absent; behaviour is exactly as above.

Test Plan:
- Load entry 0 = 0x8B150289 (ADD X9,X20,X21) with expect regWrite=1, aluControlCode=2, readRegister1=20, readRegister2=21, writeRegister=9, all else 0, mask all-ones. Load entry 1 = 0x910006D6 (ADDI X22,X22,#1) with expect regWrite=1, aluSRC=1, regs 22/22. N=2, real Processor on ctrl_in -> done after 2*2+1=5 cycles, pass=1, mismatch_count=0.
- Same table, but entry 1 expects writeRegister=21 -> pass=0, mismatch_count=1, first_fail=1, fail_seen=1.
- Entry 1 has the wrong writeRegister with those 5 mask bits cleared -> pass=1.
- num_vectors=0, start -> done=1 and pass=1 one cycle later; instr_out unchanged.
- Reset asserted mid-run with idx=1 -> next cycle busy=0, done=0, instr_out=0, mismatch_count=0. A new start with N=1 completes in 3 cycles.
- STEP_CYCLES=1, DEPTH=4, num_vectors=9 -> clamped to 4; instr_out changes every cycle; done after 5 cycles. start pulsed during RUN is ignored.
